// File: rtl/button_event_gen.sv
// Turns the debounced button level into one-cycle press/release/long-press/auto-repeat pulses.
// All outputs are registered; press and release appear one cycle after the sampling edge.
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_db,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] holdCnt, holdCntNext;
  logic             btnQ;
  logic             rise, fall;
  logic             pressNext, releaseNext, longNext, repeatNext;

  assign rise = btn_db & ~btnQ;
  assign fall = ~btn_db & btnQ;
  assign held = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      holdCnt       <= '0;
      btnQ          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= stateNext;
      holdCnt       <= holdCntNext;
      btnQ          <= btn_db;
      press_pulse   <= pressNext;
      release_pulse <= releaseNext;
      long_pulse    <= longNext;
      repeat_pulse  <= repeatNext;
    end
  end

  // holdCnt counts completed held cycles after the event that entered the
  // current state, so terminal counts land exactly LONG/REPEAT cycles later.
  always_comb begin
    stateNext   = state;
    holdCntNext = holdCnt;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    longNext    = 1'b0;
    repeatNext  = 1'b0;
    if (!enable) begin
      stateNext   = IDLE;
      holdCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          holdCntNext = '0;
          if (rise) begin
            pressNext = 1'b1;
            stateNext = PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            releaseNext = 1'b1;
            holdCntNext = '0;
            stateNext   = IDLE;
          end else if (holdCnt == LONG_TC) begin
            longNext    = 1'b1;
            holdCntNext = '0;
            stateNext   = LONG;
          end else begin
            holdCntNext = holdCnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            releaseNext = 1'b1;
            holdCntNext = '0;
            stateNext   = IDLE;
          end else if (holdCnt == REPEAT_TC) begin
            repeatNext  = 1'b1;
            holdCntNext = '0;
          end else begin
            holdCntNext = holdCnt + 1'b1;
          end
        end
        default: begin
          stateNext   = IDLE;
          holdCntNext = '0;
        end
      endcase
    end
  end

endmodule
